// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an SPR_W x SPR_H sprite ROM and emits clipped screen pixels.
// Optional colour-key transparency via `define SPRITE_BLITTER_TRANSPARENCY_EN.
module sprite_blitter #(
    parameter int WIDTH_X = 8,
    parameter int WIDTH_Y = 7,
    parameter int SCREEN_X = 160,
    parameter int SCREEN_Y = 120,
    parameter int SPR_W = 10,
    parameter int SPR_H = 10,
    parameter int SPR_AW = 7,
    parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH_X-1:0] pos_x,
    input  logic [WIDTH_Y-1:0] pos_y,
    output logic [SPR_AW-1:0]  rom_addr,
    input  logic [2:0]         rom_color,
    output logic [WIDTH_X-1:0] vga_x,
    output logic [WIDTH_Y-1:0] vga_y,
    output logic [2:0]         vga_color,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);
    localparam int N  = SPR_W * SPR_H;
    localparam int IW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int JW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [IW-1:0] I_LAST = IW'(SPR_W - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [WIDTH_X:0] SX = (WIDTH_X + 1)'(SCREEN_X);
    localparam logic [WIDTH_Y:0] SY = (WIDTH_Y + 1)'(SCREEN_Y);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t             state;
    logic [IW-1:0]      i;
    logic [JW-1:0]      j;
    logic [CW-1:0]      cnt;
    logic [WIDTH_X-1:0] px_q;
    logic [WIDTH_Y-1:0] py_q;
    logic               plot_q;
    logic [WIDTH_X:0]   sum_x;
    logic [WIDTH_Y:0]   sum_y;
    logic               key_hit;

    // One extra bit so off-screen sums never wrap back into view.
    assign sum_x = {1'b0, px_q} + (WIDTH_X + 1)'(i);
    assign sum_y = {1'b0, py_q} + (WIDTH_Y + 1)'(j);

    assign rom_addr  = (state == RUN) ? SPR_AW'(int'(i) + int'(j) * SPR_W) : '0;
    assign vga_color = rom_color;
    assign key_hit   = (rom_color == TRANSPARENT_COLOR);

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    assign vga_plot = plot_q && !key_hit;
`else
    // Key match folds away to plot_q; every unclipped pixel is drawn.
    assign vga_plot = plot_q | (plot_q & key_hit);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            cnt    <= '0;
            px_q   <= '0;
            py_q   <= '0;
            vga_x  <= '0;
            vga_y  <= '0;
            plot_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        px_q  <= pos_x;
                        py_q  <= pos_y;
                        i     <= '0;
                        j     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    vga_x  <= sum_x[WIDTH_X-1:0];
                    vga_y  <= sum_y[WIDTH_Y-1:0];
                    plot_q <= (sum_x < SX) && (sum_y < SY);
                    cnt    <= cnt + 1'b1;
                    if (i == I_LAST) begin
                        i <= '0;
                        j <= j + 1'b1;
                    end else begin
                        i <= i + 1'b1;
                    end
                    if (cnt == C_LAST) begin
                        state <= LAST;
                        done  <= 1'b1;
                    end
                end
                LAST: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter (4x2 sprite) with a ROM model and pixel scoreboard.
module tb_sprite_blitter;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] pos_x, vga_x;
    logic [6:0] pos_y, vga_y;
    logic [6:0] rom_addr;
    logic [2:0] rom_color, vga_color;
    logic       vga_plot, busy, done;

    logic [2:0] rom [0:127];

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;
    pix_t q[$];

    int total = 0;
    int passed = 0;

    sprite_blitter #(.SPR_W(W), .SPR_H(H)) dut (
        .clk(clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .rom_addr(rom_addr), .rom_color(rom_color), .vga_x(vga_x), .vga_y(vga_y),
        .vga_color(vga_color), .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_color <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after LAST.
    task automatic blit(input int px, input int py, input bit hold, input bit poke);
        pix_t e;
        int sx, sy;
        pos_x = 8'(px);
        pos_y = 7'(py);
        start = 1'b1;
        for (int k = 0; k < N; k++) begin
            sx = px + k % W;
            sy = py + k / W;
            e.x = 8'(sx);
            e.y = 7'(sy);
            e.c = rom[k];
            e.p = (sx < 160) && (sy < 120);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
            if (rom[k] == 3'b000) e.p = 1'b0;
`endif
            q.push_back(e);
        end
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            if (!hold) start = (poke && k == 3);
            chk("busy", {31'd0, busy}, 1);
            chk("rom_addr", {25'd0, rom_addr}, (k < N) ? k : 0);
            chk("done", {31'd0, done}, (k == N) ? 1 : 0);
            if (k == 0) begin
                chk("plot_first", {31'd0, vga_plot}, 0);
            end else if (q.size() == 0) begin
                chk("queue_empty", 0, 1);
            end else begin
                e = q.pop_front();
                chk("plot", {31'd0, vga_plot}, {31'd0, e.p});
                chk("vga_x", {24'd0, vga_x}, {24'd0, e.x});
                chk("vga_y", {25'd0, vga_y}, {25'd0, e.y});
                chk("color", {29'd0, vga_color}, {29'd0, e.c});
            end
        end
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_plot", {31'd0, vga_plot}, 0);
        chk("idle_done", {31'd0, done}, 0);
    endtask

    initial begin
        for (int k = 0; k < 128; k++) rom[k] = (k == 2) ? 3'b000 : 3'((k % 7) + 1);
        reset = 1'b1;
        start = 1'b0;
        pos_x = '0;
        pos_y = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_plot", {31'd0, vga_plot}, 0);
        chk("rst_addr", {25'd0, rom_addr}, 0);
        chk("rst_x", {24'd0, vga_x}, 0);
        chk("rst_y", {25'd0, vga_y}, 0);
        reset = 1'b0;

        blit(10, 20, 1'b0, 1'b0);
        blit(158, 0, 1'b0, 1'b0);
        blit(20, 119, 1'b0, 1'b0);
        blit(250, 5, 1'b0, 1'b0);

        // start pulsed mid-blit must not queue another blit
        blit(30, 40, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_requeue_busy", {31'd0, busy}, 0);
        end

        // start held: exactly one idle cycle between blits
        blit(1, 2, 1'b1, 1'b0);
        blit(1, 2, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk("held_stop_busy", {31'd0, busy}, 0);

        // reset during the 4th RUN cycle, together with start
        pos_x = 8'd5;
        pos_y = 7'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_plot", {31'd0, vga_plot}, 0);
        chk("abort_addr", {25'd0, rom_addr}, 0);
        chk("abort_done", {31'd0, done}, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_done", {31'd0, done}, 0);
            chk("post_abort_busy", {31'd0, busy}, 0);
        end
        blit(0, 0, 1'b0, 1'b0);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter WIDTH_X, default 8: screen x coordinate width in bits.
REQ-002 Parameter WIDTH_Y, default 7: screen y coordinate width in bits.
REQ-003 Parameter SCREEN_X, default 160: visible screen width in pixels.
REQ-004 Parameter SCREEN_Y, default 120: visible screen height in pixels.
REQ-005 Parameter SPR_W, default 10: sprite width in pixels.
REQ-006 Parameter SPR_H, default 10: sprite height in pixels.
REQ-007 Parameter SPR_AW, default 7: sprite ROM address width; must satisfy 2^SPR_AW >= SPR_W*SPR_H.
REQ-008 Parameter TRANSPARENT_COLOR, default 3'b000: key color, used only with the transparency feature.
REQ-009 Single clock; reset is synchronous and active-high.
REQ-010 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a blit; sampled in IDLE only.
- pos_x  in  WIDTH_X  sprite top-left screen x; latched on an accepted start.
- pos_y  in  WIDTH_Y  sprite top-left screen y; latched on an accepted start.
- rom_addr  out  SPR_AW  sprite ROM address; the ROM has 1-cycle read latency.
- rom_color  in  3  ROM data for the address presented one cycle earlier.
- vga_x  out  WIDTH_X  plot x.
- vga_y  out  WIDTH_Y  plot y.
- vga_color  out  3  plot color; equals rom_color combinationally.
- vga_plot  out  1  pixel write enable.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-011 States are IDLE, RUN and LAST.
- IDLE->RUN on start=1.
- RUN->LAST when the pixel counter reaches N-1, where N=SPR_W*SPR_H.
- LAST->IDLE unconditionally.
REQ-012 On accepted start: latch pos_x/pos_y, clear counters i (column) and j (row).
REQ-013 In RUN, each cycle: rom_addr = i + j*SPR_W, truncated to SPR_AW bits.
- i increments each cycle.
- At i = SPR_W-1, i wraps to 0 and j increments.
REQ-014 In IDLE and LAST, rom_addr holds 0.
REQ-015 Each RUN cycle registers one pixel into vga_x/vga_y:
- vga_x = pos_x+i; vga_y = pos_y+j.
- The pixel is visible on the next cycle, giving 1-cycle latency aligned to rom_color.
REQ-016 Clipping:
- Sums are formed at WIDTH_X+1 / WIDTH_Y+1 bits.
- A pixel with sum_x >= SCREEN_X or sum_y >= SCREEN_Y has vga_plot=0.
- Clipped pixels still consume their cycle.
REQ-017 Outside the output cycle of a pixel, vga_plot=0; vga_x/vga_y hold their last value.
REQ-018 done=1 exactly in LAST, coinciding with output of pixel N-1.
REQ-019 Timing per blit: busy high N+1 cycles; at most N vga_plot cycles; done high 1 cycle.
REQ-020 start during busy is ignored and is not queued.
REQ-021 start held high in the cycle after LAST (state IDLE) begins a new blit.
- Back-to-back blits therefore have one IDLE cycle between them.
REQ-022 SPR_W=1 or SPR_H=1 is legal. N=1 gives RUN for one cycle, then LAST.

Reset
REQ-023 On reset=1 at a clock edge:
- state = IDLE.
- i, j, latched position, rom_addr, vga_x, vga_y, vga_plot, busy, done all = 0.
REQ-024 Reset mid-blit aborts immediately:
- No further vga_plot.
- done is not pulsed.
- reset overrides a simultaneous start.

Configuration
REQ-025 Macro SPRITE_BLITTER_TRANSPARENCY_EN:
- When defined, vga_plot is additionally forced 0 whenever rom_color == TRANSPARENT_COLOR.
- When undefined, every unclipped pixel is plotted regardless of color, and TRANSPARENT_COLOR is unused.

Verification
REQ-026 Basic blit. Setup: SPR_W=4, SPR_H=2, pos=(10,20), start pulsed one cycle.
- rom_addr = 0..7 on consecutive cycles.
- vga_plot high 8 cycles at (10..13,20) then (10..13,21).
- done high on the (13,21) cycle.
- busy high 9 cycles.
REQ-027 Clipping. Setup: SCREEN_X=160, pos=(158,0), 4x2 sprite.
- Only x=158,159 are plotted per row: 4 vga_plot cycles.
- done is still asserted after 9 busy cycles.
REQ-028 Transparency. Setup: macro defined, ROM word 2 = TRANSPARENT_COLOR, all other words 3'b111.
- vga_plot is low only on the output cycle of pixel 2.
- Without the macro, all 8 pixels are plotted.
REQ-029 Reset mid-operation. reset asserted on the 4th RUN cycle.
- Next cycle: busy=0, vga_plot=0, rom_addr=0.
- done is never asserted.
- A subsequent start runs a full, correct blit.
REQ-030 start handling.
- start pulsed again during busy: ignored, exactly one done.
- start held high continuously: blits repeat with exactly 1 IDLE cycle between LAST and the next RUN.
